// File: rtl/bus_types_pkg.sv
// Shared types and constants for the internal register bus master.
package bus_types;

  localparam int unsigned DEFAULT_ADDR_W = 8;

  // Status word returned when a handshake is abandoned; low bits carry the address.
  localparam logic [31:0] TIMEOUT_STATUS = 32'hDEAD_0000;

  localparam logic [7:0] SYS_INFO_0  = 8'h00;
  localparam logic [7:0] SYS_BUS_ARB = 8'hF0;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StSetup,
    StDataH1,
    StDataRel,
    StStatH1,
    StStatRel,
    StDone
  } bus_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PtrW    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]    idx_o,
  output logic               valid_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = PtrW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin master of the 32-bit register bus with two-phase (data, status) handshake.
// Optional handshake watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_master_arbiter
  import bus_types::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [31:0]             rdata,
  output logic [31:0]             status,
  output logic                    fault,
  output logic                    timeout,
  output logic [ADDR_W-1:0]       bus_reg_address,
  output logic                    bus_RW,
  output logic                    bus_register_address_valid,
  output logic                    bus_handshake_1,
  input  logic                    bus_handshake_2,
  output logic [31:0]             bus_data_out,
  input  logic [31:0]             bus_data_in,
  input  logic                    bus_nFault
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bus_arb_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d, rdata_q, rdata_d, status_q, status_d;
  logic               fault_q, fault_d, timeout_q, timeout_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PtrW-1:0]    arb_idx;
  logic               arb_valid;
  logic               rw_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [31:0]        wdata_sel;
  logic               in_wait;
  logic               expired;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PtrW   (PtrW)
  ) u_rr_arbiter (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  always_comb begin
    rw_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        rw_sel    = req_rw[i];
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = req_wdata[i*32 +: 32];
      end
    end
  end

  assign in_wait = state_q inside {StDataH1, StDataRel, StStatH1, StStatRel};

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer_q, timer_d;

  assign expired = in_wait && (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
  // Leaving or entering a wait state restarts the count.
  assign timer_d = (in_wait && state_d == state_q) ? timer_q + TimerW'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic unused_timeout_cfg;
  assign expired            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: if (|req) state_d = StArb;
      StArb: begin
        if (arb_valid) begin
          grant_d   = arb_gnt;
          ptr_d     = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + PtrW'(1);
          rw_d      = rw_sel;
          addr_d    = addr_sel;
          wdata_d   = wdata_sel;
          rdata_d   = '0;
          status_d  = '0;
          fault_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: state_d = StDataH1;
      StDataH1: begin
        if (bus_handshake_2) begin
          if (rw_q) rdata_d = bus_data_in;
          state_d = StDataRel;
        end
      end
      StDataRel: if (!bus_handshake_2) state_d = StStatH1;
      StStatH1: begin
        if (bus_handshake_2) begin
          status_d = bus_data_in;
          state_d  = StStatRel;
        end
      end
      StStatRel: if (!bus_handshake_2) state_d = StDone;
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An X/Z nFault compares unknown and therefore never sets the flag.
    if (in_wait && bus_nFault == 1'b0) fault_d = 1'b1;

    if (expired && state_d == state_q) begin
      timeout_d = 1'b1;
      status_d  = TIMEOUT_STATUS | 32'(addr_q);
      rdata_d   = '0;
      state_d   = StDone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant                      = grant_q;
  assign done                       = (state_q == StDone) ? grant_q : '0;
  assign rdata                      = rdata_q;
  assign status                     = status_q;
  assign fault                      = fault_q;
  assign timeout                    = timeout_q;
  assign bus_reg_address            = addr_q;
  assign bus_RW                     = rw_q;
  assign bus_data_out               = wdata_q;
  assign bus_handshake_1            = state_q inside {StDataH1, StStatH1};
  assign bus_register_address_valid = state_q inside {StSetup, StDataH1, StDataRel,
                                                      StStatH1, StStatRel};

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Sole master of the internal 32-bit register bus.
- Accepts register read/write requests from NUM_REQ requesters, e.g. host uP interface and on-chip sequencer.
- Arbitrates round-robin and runs the two-phase handshake (data word, then status word) against the subsystem that decodes the address.
- Returns read data, status word and fault/timeout indication to the granted requester; register_error answers unmapped addresses.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 8, register address width
TIMEOUT_CYCLES, 255, max cycles waiting on any handshake_2 edge before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request, held until done
req_rw  in  NUM_REQ  1=read, 0=write
req_addr  in  NUM_REQ*ADDR_W  packed register addresses
req_wdata  in  NUM_REQ*32  packed write data
grant  out  NUM_REQ  one-hot, high from ARB until done
done  out  NUM_REQ  one-cycle completion pulse to granted requester
rdata  out  32  read data, valid with done
status  out  32  status word, valid with done
fault  out  1  bus nFault seen low during transaction, valid with done
timeout  out  1  handshake timed out, valid with done
bus_reg_address  out  ADDR_W  address to subsystems
bus_RW  out  1  1=read
bus_register_address_valid  out  1  address/RW stable
bus_handshake_1  out  1  master strobe
bus_handshake_2  in  1  subsystem acknowledge
bus_data_out  out  32  write data
bus_data_in  in  32  data/status from subsystem
bus_nFault  in  1  active-low fault

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0, timer = 0; reset mid-transaction aborts without done.
- States:
  - IDLE: if any req, go ARB.
  - ARB: pick first requesting index at or after pointer (wrapping); latch rw/addr/wdata; assert grant; pointer <= winner+1 mod NUM_REQ; go SETUP.
  - SETUP: drive address/RW/data_out, assert register_address_valid; one cycle; go D_H1.
  - D_H1: handshake_1=1; wait handshake_2=1; on read capture bus_data_in into rdata; go D_REL.
  - D_REL: handshake_1=0; wait handshake_2=0; go S_H1.
  - S_H1/S_REL: same as the data phase; capture status.
  - DONE: pulse done, drop grant and register_address_valid; go IDLE.
- Minimum transaction 7 cycles; new ARB earliest the cycle after DONE, so back-to-back is one idle cycle.
- Latched fields are immune to requester changes after ARB.
- fault: sticky OR of !bus_nFault sampled in D_H1..S_REL; bus_nFault of X/Z counts as not-fault.
- Timer: cleared on entry to each wait state. Reaching TIMEOUT_CYCLES sets timeout and status=32'hDEAD_0000|addr, rdata=0, drops handshake_1, goes DONE.
- A req deasserted while granted does not cancel the transaction; done still pulses.
- Simultaneous requests follow round-robin; a single persistent requester is re-granted each transaction.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- Defined: timer and timeout behaviour as above.
- Undefined: no timer; wait states wait indefinitely; timeout output tied 0.

Decomposition:
- Package `bus_types`: state enum `bus_arb_state_t`, `TIMEOUT_STATUS` constant (32'hDEAD_0000), `ADDR_W` default.
- Add a `SYS_BUS_ARB` address constant to global constants if needed.
- One sub-module `rr_arbiter`: combinational one-hot pick from request vector and pointer; pointer register stays in the parent.

Test Plan:
- Read of SYS_INFO_0 via req[0]; subsystem model sends h2 after 3 cycles, data 32'h55555555 -> rdata=32'h55555555, status from model, done[0] pulses once.
- Write 32'h12345678 to addr 8'h10 via req[1] -> bus_data_out=32'h12345678, bus_RW=0 throughout, done[1] pulse.
- Both req held continuously -> grants alternate 0,1,0,1; no starvation over 8 transactions.
- Model never raises h2, TIMEOUT_CYCLES=16 -> timeout=1, status=32'hDEAD_0010, done within 16+3 cycles.
- Model drives bus_nFault=0 during data phase -> fault=1 with done; next transaction fault=0.
- Assert reset in D_H1 -> next cycle all outputs 0, state IDLE; no done pulse.
